// File: rtl/dll_track_core.sv
// DLL early/late tracker: saturating integrate-and-dump accumulators feeding
// a 4-stage discriminator pipeline and a saturating NCO correction register.
module dll_track_core #(
    parameter int IN_W   = 16,
    parameter int ACC_W  = 32,
    parameter int N_INT  = 10000,
    parameter int KSHIFT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [IN_W-1:0]    in_e_i,
    input  logic signed [IN_W-1:0]    in_e_q,
    input  logic signed [IN_W-1:0]    in_l_i,
    input  logic signed [IN_W-1:0]    in_l_q,
    input  logic                      mode,
    output logic signed [2*ACC_W+1:0] disc,
    output logic                      disc_valid,
    output logic signed [31:0]        correction,
    output logic                      corr_valid,
    output logic                      acc_ovf
);
    localparam int DISC_W = 2*ACC_W+2;
    localparam int SQ_W   = 2*ACC_W;
    localparam int PW_W   = 2*ACC_W+1;
    localparam int DF_W   = ACC_W+1;
    localparam int CNT_W  = (N_INT > 1) ? $clog2(N_INT) : 1;

    localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [DISC_W:0]  CMAX = (DISC_W+1)'(32'sh7fffffff);
    localparam logic signed [DISC_W:0]  CMIN = (DISC_W+1)'(32'sh80000000);

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  smp [4];
    logic signed [ACC_W-1:0]  acc_q [4];
    logic signed [ACC_W-1:0]  acc_d [4];
    logic signed [ACC_W-1:0]  sum_sat [4];
    logic signed [ACC_W-1:0]  dmp_q [4];
    logic signed [ACC_W:0]    sum_w [4];
    logic signed [SQ_W-1:0]   sq_q [4];
    logic signed [DF_W-1:0]   dif1_q, dif2_q;
    logic signed [PW_W-1:0]   pe_q, pl_q;
    logic signed [DISC_W-1:0] disc_q, disc_d, step;
    logic signed [DISC_W:0]   csum;
    logic signed [31:0]       corr_q, corr_d;
    logic                     sat_any, dump;
    logic                     v0_q, v1_q, v2_q, dv_q, cv_q;
    logic                     m0_q, m1_q, m2_q, ovf_q;

    always_comb begin
        smp[0]  = ACC_W'(in_e_i);
        smp[1]  = ACC_W'(in_e_q);
        smp[2]  = ACC_W'(in_l_i);
        smp[3]  = ACC_W'(in_l_q);
        sat_any = 1'b0;
        dump    = in_valid && (cnt_q == CNT_W'(N_INT-1));
        for (int i = 0; i < 4; i++) begin
            sum_w[i]   = DF_W'(acc_q[i]) + DF_W'(smp[i]);
            sum_sat[i] = sum_w[i][ACC_W-1:0];
            // top two bits disagree: the add left the ACC_W range
            if (sum_w[i][ACC_W] != sum_w[i][ACC_W-1]) begin
                sum_sat[i] = sum_w[i][ACC_W] ? AMIN : AMAX;
                sat_any    = 1'b1;
            end
            acc_d[i] = dump ? '0 : sum_sat[i];
        end
        cnt_d  = dump ? '0 : cnt_q + CNT_W'(1);
        disc_d = m2_q ? DISC_W'(dif2_q)
                      : DISC_W'(pe_q) - DISC_W'(pl_q);
        step   = disc_q >>> KSHIFT;
        csum   = (DISC_W+1)'(step) + (DISC_W+1)'(corr_q);
        corr_d = csum[31:0];
        if (csum > CMAX) begin
            corr_d = 32'sh7fffffff;
        end else if (csum < CMIN) begin
            corr_d = 32'sh80000000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
                dmp_q[i] <= '0;
                sq_q[i]  <= '0;
            end
            dif1_q <= '0;
            dif2_q <= '0;
            pe_q   <= '0;
            pl_q   <= '0;
            disc_q <= '0;
            corr_q <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            dv_q   <= 1'b0;
            cv_q   <= 1'b0;
            m0_q   <= 1'b0;
            m1_q   <= 1'b0;
            m2_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (in_valid) begin
                cnt_q <= cnt_d;
                for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
            end
            if (in_valid && sat_any) ovf_q <= 1'b1;
            if (dump) begin
                for (int i = 0; i < 4; i++) dmp_q[i] <= sum_sat[i];
                m0_q <= mode;
            end
            v0_q <= dump;
            // free-running stages; only the valid/mode tags qualify them
            for (int i = 0; i < 4; i++)
                sq_q[i] <= SQ_W'(dmp_q[i]) * SQ_W'(dmp_q[i]);
            dif1_q <= DF_W'(dmp_q[0]) - DF_W'(dmp_q[2]);
            m1_q   <= m0_q;
            v1_q   <= v0_q;
            pe_q   <= PW_W'(sq_q[0]) + PW_W'(sq_q[1]);
            pl_q   <= PW_W'(sq_q[2]) + PW_W'(sq_q[3]);
            dif2_q <= dif1_q;
            m2_q   <= m1_q;
            v2_q   <= v1_q;
            if (v2_q) disc_q <= disc_d;
            dv_q <= v2_q;
            if (dv_q) corr_q <= corr_d;
            cv_q <= dv_q;
        end
    end

    assign disc       = disc_q;
    assign disc_valid = dv_q;
    assign correction = corr_q;
    assign corr_valid = cv_q;
    assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_dll_track_core.sv
// Directed bench for dll_track_core: four parameterisations, a bench-side
// model pushes expected disc/correction to queues, a monitor pops on strobes.
module tb_dll_track_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]        rstn, vld;
    logic signed [15:0] ei, eq, li, lq;
    logic              md;
    logic signed [65:0] d0, d1, d3;
    logic signed [41:0] d2;
    logic signed [31:0] c0, c1, c2, c3;
    logic [3:0]        dv, cv, ovf;

    typedef struct {
        int                  k;
        logic signed [127:0] v;
    } exp_t;

    exp_t dq[$];
    exp_t cq[$];
    int total = 0;
    int bad   = 0;

    int accw[4] = '{32, 32, 20, 32};
    int nint[4] = '{4, 4, 32, 1};
    int ksh[4]  = '{4, 0, 0, 0};
    longint ma[4][4];
    int     mcnt[4];
    longint mcorr[4];
    localparam longint CMX = 64'sd2147483647;
    localparam longint CMN = -64'sd2147483648;

    dll_track_core #(.IN_W(16), .ACC_W(32), .N_INT(4), .KSHIFT(4)) u0 (
        .clk(clk), .rst(rstn[0]), .in_valid(vld[0]),
        .in_e_i(ei), .in_e_q(eq), .in_l_i(li), .in_l_q(lq), .mode(md),
        .disc(d0), .disc_valid(dv[0]), .correction(c0),
        .corr_valid(cv[0]), .acc_ovf(ovf[0]));
    dll_track_core #(.IN_W(16), .ACC_W(32), .N_INT(4), .KSHIFT(0)) u1 (
        .clk(clk), .rst(rstn[1]), .in_valid(vld[1]),
        .in_e_i(ei), .in_e_q(eq), .in_l_i(li), .in_l_q(lq), .mode(md),
        .disc(d1), .disc_valid(dv[1]), .correction(c1),
        .corr_valid(cv[1]), .acc_ovf(ovf[1]));
    dll_track_core #(.IN_W(16), .ACC_W(20), .N_INT(32), .KSHIFT(0)) u2 (
        .clk(clk), .rst(rstn[2]), .in_valid(vld[2]),
        .in_e_i(ei), .in_e_q(eq), .in_l_i(li), .in_l_q(lq), .mode(md),
        .disc(d2), .disc_valid(dv[2]), .correction(c2),
        .corr_valid(cv[2]), .acc_ovf(ovf[2]));
    dll_track_core #(.IN_W(16), .ACC_W(32), .N_INT(1), .KSHIFT(0)) u3 (
        .clk(clk), .rst(rstn[3]), .in_valid(vld[3]),
        .in_e_i(ei), .in_e_q(eq), .in_l_i(li), .in_l_q(lq), .mode(md),
        .disc(d3), .disc_valid(dv[3]), .correction(c3),
        .corr_valid(cv[3]), .acc_ovf(ovf[3]));

    task automatic chk(input string tag, input logic signed [127:0] obs,
                       input logic signed [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic mon(input int k, input logic s_dv, input logic s_cv,
                       input logic signed [127:0] d,
                       input logic signed [31:0] c);
        exp_t e;
        if (s_dv) begin
            chk($sformatf("disc_expected_u%0d", k), 128'(dq.size() > 0), 1);
            if (dq.size() > 0) begin
                e = dq.pop_front();
                chk($sformatf("disc_inst_u%0d", k), e.k, k);
                chk($sformatf("disc_u%0d", k), d, e.v);
            end
        end
        if (s_cv) begin
            chk($sformatf("corr_expected_u%0d", k), 128'(cq.size() > 0), 1);
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk($sformatf("corr_inst_u%0d", k), e.k, k);
                chk($sformatf("corr_u%0d", k), c, e.v);
            end
        end
    endtask

    task automatic send(input int k, input logic v, input int xei,
                        input int xeq, input int xli, input int xlq,
                        input logic xmd);
        longint x[4];
        longint lim, s;
        logic signed [127:0] a[4];
        logic signed [127:0] dsc, nc;
        exp_t e;
        vld    = '0;
        vld[k] = v;
        ei = 16'(xei);
        eq = 16'(xeq);
        li = 16'(xli);
        lq = 16'(xlq);
        md = xmd;
        @(posedge clk);
        #1;
        vld = '0;
        if (v) begin
            x   = '{longint'(xei), longint'(xeq), longint'(xli), longint'(xlq)};
            lim = longint'(1) <<< (accw[k] - 1);
            for (int i = 0; i < 4; i++) begin
                s = ma[k][i] + x[i];
                if (s > lim - 1) s = lim - 1;
                else if (s < -lim) s = -lim;
                ma[k][i] = s;
            end
            mcnt[k]++;
            if (mcnt[k] == nint[k]) begin
                for (int i = 0; i < 4; i++) a[i] = ma[k][i];
                if (xmd) dsc = a[0] - a[2];
                else dsc = a[0]*a[0] + a[1]*a[1] - a[2]*a[2] - a[3]*a[3];
                nc = mcorr[k] + (dsc >>> ksh[k]);
                if (nc > CMX) nc = CMX;
                else if (nc < CMN) nc = CMN;
                mcorr[k] = longint'(nc);
                e.k = k;
                e.v = dsc;
                dq.push_back(e);
                e.v = nc;
                cq.push_back(e);
                mcnt[k] = 0;
                for (int i = 0; i < 4; i++) ma[k][i] = 0;
            end
        end
    endtask

    task automatic rstk(input int k);
        vld     = '0;
        rstn[k] = 1'b0;
        @(posedge clk);
        #1;
        rstn[k]  = 1'b1;
        mcnt[k]  = 0;
        mcorr[k] = 0;
        for (int i = 0; i < 4; i++) ma[k][i] = 0;
        dq.delete();
        cq.delete();
    endtask

    task automatic drain(input string tag);
        repeat (8) @(posedge clk);
        #1;
        chk(tag, dq.size() + cq.size(), 0);
    endtask

    initial begin
        rstn = '0;
        vld  = '0;
        ei = 0; eq = 0; li = 0; lq = 0; md = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mcnt[k]  = 0;
            mcorr[k] = 0;
            for (int i = 0; i < 4; i++) ma[k][i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rstn = '1;
        chk("rst_disc_u0", d0, 0);
        chk("rst_disc_u2", d2, 0);
        chk("rst_corr_u0", c0, 0);
        chk("rst_corr_u3", c3, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dv", dv, 0);
        chk("rst_cv", cv, 0);

        fork
            forever begin
                @(negedge clk);
                mon(0, dv[0], cv[0], d0, c0);
                mon(1, dv[1], cv[1], d1, c1);
                mon(2, dv[2], cv[2], d2, c2);
                mon(3, dv[3], cv[3], d3, c3);
            end
        join_none

        // power discriminator with latency checks
        repeat (4) send(0, 1, 100, 0, 0, 0, 0);
        @(posedge clk); #1; chk("lat_dv_p1", dv[0], 0);
        @(posedge clk); #1; chk("lat_dv_p2", dv[0], 0);
        @(posedge clk); #1; chk("lat_dv_p3", dv[0], 1);
        chk("lat_disc_p3", d0, 160000);
        @(posedge clk); #1; chk("lat_cv_p4", cv[0], 1);
        chk("lat_corr_p4", c0, 10000);
        chk("lat_dv_off", dv[0], 0);
        drain("drain_pow");
        chk("disc_hold", d0, 160000);

        // coherent mode; mode flips mid-pipeline must not matter
        repeat (4) send(1, 1, 100, 0, 40, 0, 1);
        repeat (2) send(1, 0, 0, 0, 0, 0, 0);
        repeat (4) send(1, 1, 40, 0, 100, 0, 1);
        send(1, 0, 0, 0, 0, 0, 0);
        drain("drain_coh");
        chk("coh_disc_neg", d1, -240);
        chk("coh_corr_net", c1, 0);

        // gapped valid: one dump on the 4th valid sample
        send(0, 1, 10, 0, 0, 0, 0);
        send(0, 0, 10, 0, 0, 0, 0);
        send(0, 0, 10, 0, 0, 0, 0);
        send(0, 1, 10, 0, 0, 0, 0);
        send(0, 1, 10, 0, 0, 0, 0);
        send(0, 0, 10, 0, 0, 0, 0);
        send(0, 1, 10, 0, 0, 0, 0);
        drain("drain_gap");
        chk("gap_disc", d0, 1600);
        chk("gap_corr", c0, 10100);

        // reset mid-integration
        repeat (2) send(0, 1, 1, 0, 0, 0, 0);
        rstk(0);
        chk("midrst_disc", d0, 0);
        chk("midrst_corr", c0, 0);
        repeat (4) send(0, 0, 0, 0, 0, 0, 0);
        repeat (4) send(0, 1, 1, 0, 0, 0, 0);
        drain("drain_rst");
        chk("rst_disc16", d0, 16);
        chk("rst_corr1", c0, 1);

        // reset right after a dump kills the in-flight result
        repeat (4) send(1, 1, 5, 0, 0, 0, 0);
        rstk(1);
        repeat (6) send(1, 0, 0, 0, 0, 0, 0);
        chk("pipe_rst_disc", d1, 0);
        chk("pipe_rst_dv", dv[1], 0);

        // accumulator clamp and correction saturation
        repeat (32) send(2, 1, 32767, 0, 0, 0, 0);
        chk("ovf_set", ovf[2], 1);
        chk("ovf_other", ovf[0], 0);
        drain("drain_sat1");
        chk("sat_disc", d2, 64'sd274876858369);
        chk("sat_corr1", c2, 2147483647);
        repeat (32) send(2, 1, 32767, 0, 0, 0, 0);
        drain("drain_sat2");
        chk("sat_corr2", c2, 2147483647);
        chk("ovf_sticky", ovf[2], 1);
        rstk(2);
        chk("ovf_clear", ovf[2], 0);

        // N_INT=1 back-to-back results
        send(3, 1, 3, 2, 4, 1, 0);
        send(3, 1, -7, 2, 4, 1, 0);
        send(3, 1, 20, -5, 3, -2, 1);
        send(3, 1, 0, 0, 9, 0, 0);
        send(3, 1, 11, 6, -2, 8, 1);
        send(3, 1, 300, 0, 0, 0, 0);
        drain("drain_n1");
        chk("n1_corr", c3, mcorr[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dll_track_core.md
DLL_TRACK_CORE -- requirements
Module: dll_track_core

Interface
REQ-001 Parameter IN_W, default 16, width of signed correlator input samples.
REQ-002 Parameter ACC_W, default 32, width of signed integrate-and-dump accumulators (ACC_W > IN_W).
REQ-003 Parameter N_INT, default 10000, number of accepted samples per integration period (N_INT >= 1).
REQ-004 Parameter KSHIFT, default 8, loop-filter gain expressed as an arithmetic right shift of the discriminator.
REQ-005 Localparam DISC_W = 2*ACC_W+2, discriminator width.
REQ-006 clk  in  1  clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset; synchronous, active-low.
REQ-008 in_valid  in  1  high when the current sample set is to be accumulated.
REQ-009 in_e_i, in_e_q, in_l_i, in_l_q  in  IN_W each  signed early/late I/Q correlator samples.
REQ-010 mode  in  1  discriminator select: 0 = non-coherent power E-L, 1 = coherent E-L on I arm.
REQ-011 disc  out  DISC_W  signed discriminator result.
REQ-012 disc_valid  out  1  one-cycle strobe qualifying disc.
REQ-013 correction  out  32  signed NCO correction word.
REQ-014 corr_valid  out  1  one-cycle strobe, high when correction has just updated.
REQ-015 acc_ovf  out  1  sticky flag, high once any accumulator has saturated.

Function
REQ-016 Sample count cnt SHALL advance only on cycles with in_valid=1; it SHALL hold when in_valid=0.
REQ-017 With in_valid=1, each accumulator SHALL add its sign-extended input, saturating at ±(2^(ACC_W-1)) limits (max positive 2^(ACC_W-1)-1), and any saturation SHALL set acc_ovf.
REQ-018 On the accepted sample where cnt = N_INT-1 (the dump cycle), the four sums including that sample SHALL be latched into dump registers, accumulators SHALL reload to 0, and cnt SHALL reset to 0.
REQ-019 mode SHALL be sampled at the dump cycle and carried through the pipeline with that period's data; mid-pipeline mode changes SHALL NOT affect an in-flight result.
REQ-020 Stage 1 (dump+1): four registered squares, each 2*ACC_W bits.
REQ-021 Stage 2 (dump+2): registered powers PE = EI²+EQ², PL = LI²+LQ², each 2*ACC_W+1 bits, without truncation.
REQ-022 Stage 3 (dump+3): disc = PE-PL when mode=0, or sign-extended (sum_e_i - sum_l_i) when mode=1; disc_valid SHALL pulse for exactly one cycle.
REQ-023 Stage 4 (dump+4): correction SHALL become correction + (disc >>> KSHIFT), saturated to the signed 32-bit range; corr_valid SHALL pulse for exactly one cycle.
REQ-024 With N_INT=1, every accepted sample SHALL be a dump cycle, and the pipeline SHALL sustain one result per accepted cycle without loss.
REQ-025 disc and correction SHALL hold their values between strobes.
REQ-026 A dump cycle coinciding with an in-flight stage SHALL NOT stall either one; stages are free-running registers.

Reset
REQ-027 With rst=0 at a rising edge, the block SHALL clear cnt, all accumulators, dump and pipeline registers, disc, correction and acc_ovf to 0, and drive disc_valid=corr_valid=0.
REQ-028 Reset asserted mid-integration or mid-pipeline SHALL discard partial sums and in-flight results; no strobe SHALL follow the reset.
REQ-029 The first sample accepted after reset release SHALL be sample 0 of a new period.

Verification
REQ-030 N_INT=4, KSHIFT=4, mode=0, e_i=100 and others 0 for 4 consecutive valid cycles -> disc=160000 with disc_valid 3 cycles after the 4th sample, then correction=10000 with corr_valid the cycle after.
REQ-031 N_INT=4, mode=1, e_i=100, l_i=40 -> disc=240; repeat with e_i/l_i swapped -> disc=-240, and correction accumulates both results (net 0 with KSHIFT=0).
REQ-032 N_INT=4, in_valid toggled 1,0,0,1,1,0,1 with e_i=10 -> single dump on the 4th valid sample, disc=1600 (mode 0).
REQ-033 rst=0 asserted after 2 of 4 samples, released, then 4 samples of e_i=1 -> disc=16, no strobe during or immediately after reset.
REQ-034 ACC_W=20, N_INT=32, e_i=32767 constant -> sum_e_i clamps at 524287, acc_ovf=1 and stays 1 until reset.
REQ-035 KSHIFT=0, repeated large positive disc -> correction saturates at 2147483647 and does not wrap.
